flex_serializer: RTL and testbench

- Parametrised successor to the team's fixed 16-bit serializer.
- Converts a DATA_W-bit parallel word into a 1-bit stream of programmable length.
- Adds the following over the fixed version:
  - run-time MSB/LSB-first order, latched per word
  - downstream backpressure (ser_ready_i)
  - last-bit flag
  - synchronous flush
- Sits between a parallel word producer and a bit-serial link/PHY.

---
 rtl/flex_serializer_pkg.sv | 24 ++
 rtl/flex_serializer_shreg.sv | 66 ++++++
 rtl/flex_serializer.sv | 174 +++++++++++++++++
 tb/tb_flex_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_serializer_pkg.sv
// Shared types and helpers for flex_serializer: FSM state encoding, default
// minimum length, and the data_mod_i -> effective length decoder.
package flex_serializer_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam int unsigned MIN_LEN_DEFAULT = 3;

    typedef struct packed {
        logic [31:0] len;
        logic        legal;
    } len_info_t;

    // A mod of 0 selects the full word; short nonzero lengths are flagged illegal.
    function automatic len_info_t len_decode(input int unsigned mod,
                                             input int unsigned data_w,
                                             input int unsigned min_len);
        len_info_t r;
        r.len   = (mod == 0) ? data_w : mod;
        r.legal = (mod == 0) || (mod >= min_len);
        return r;
    endfunction

endpackage

// File: rtl/flex_serializer_shreg.sv
// Word holding register with per-word bit order and a saturating bit counter.
// Priority: clear over load over advance.
module flex_serializer_shreg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W:0]    len_i,
    input  logic              msb_first_i,
    output logic              bit_o,
    output logic              last_o
);

    localparam logic [MOD_W-1:0] TopIdx = MOD_W'(DATA_W - 1);

    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W:0]    len_q, len_d;
    logic [MOD_W:0]    cnt_q, cnt_d;
    logic              msb_q, msb_d;
    logic [MOD_W-1:0]  idx;

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        msb_d  = msb_q;
        if (clear_i) begin
            data_d = '0;
            len_d  = '0;
            cnt_d  = '0;
            msb_d  = 1'b0;
        end else if (load_i) begin
            data_d = data_i;
            len_d  = len_i;
            cnt_d  = '0;
            msb_d  = msb_first_i;
        end else if (advance_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            msb_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            msb_q  <= msb_d;
        end
    end

    // Count never exceeds len-1 < DATA_W, so its low MOD_W bits address the word.
    assign idx    = msb_q ? (TopIdx - cnt_q[MOD_W-1:0]) : cnt_q[MOD_W-1:0];
    assign bit_o  = data_q[idx];
    assign last_o = (cnt_q == (len_q - 1'b1));

endmodule

// File: rtl/flex_serializer.sv
// Parallel-to-serial converter with programmable length, per-word bit order,
// backpressure and flush. FLEX_SERIALIZER_PRELOAD_EN adds a one-word pending buffer.
module flex_serializer
    import flex_serializer_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MOD_W   = $clog2(DATA_W),
    parameter int unsigned MIN_LEN = MIN_LEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_msb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    input  logic              ser_ready_i,
    output logic              busy_o
);

    localparam int unsigned CW = MOD_W + 1;

    state_t            state_q, state_d;
    logic              rdy_q, rdy_d;
    len_info_t         in_info;
    logic [CW-1:0]     in_len;
    logic              accept, xfer, last_xfer;
    logic              load, clear;
    logic [DATA_W-1:0] load_data;
    logic [CW-1:0]     load_len;
    logic              load_msb;
    logic              sh_bit, sh_last;

    always_comb in_info = len_decode(32'(data_mod_i), DATA_W, MIN_LEN);
    assign in_len    = CW'(in_info.len);
    assign accept    = data_val_i && rdy_q && !flush_i;
    assign xfer      = (state_q == SHIFT) && ser_ready_i;
    assign last_xfer = xfer && sh_last;

`ifdef FLEX_SERIALIZER_PRELOAD_EN
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [CW-1:0]     pend_len_q, pend_len_d;
    logic              pend_msb_q, pend_msb_d;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        clear       = 1'b0;
        load_data   = data_i;
        load_len    = in_len;
        load_msb    = data_msb_first_i;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        pend_len_d  = pend_len_q;
        pend_msb_d  = pend_msb_q;
        if (flush_i) begin
            state_d     = IDLE;
            clear       = 1'b1;
            pend_full_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && in_info.legal) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) begin
                        // Chain the next word straight in so no bubble appears.
                        if (pend_full_q) begin
                            load        = 1'b1;
                            load_data   = pend_data_q;
                            load_len    = pend_len_q;
                            load_msb    = pend_msb_q;
                            pend_full_d = 1'b0;
                        end else if (accept && in_info.legal) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (accept && in_info.legal) begin
                        pend_full_d = 1'b1;
                        pend_data_d = data_i;
                        pend_len_d  = in_len;
                        pend_msb_d  = data_msb_first_i;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        rdy_d = !pend_full_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            pend_len_q  <= '0;
            pend_msb_q  <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            pend_len_q  <= pend_len_d;
            pend_msb_q  <= pend_msb_d;
        end
    end
`else
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        clear     = 1'b0;
        load_data = data_i;
        load_len  = in_len;
        load_msb  = data_msb_first_i;
        if (flush_i) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && in_info.legal) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        rdy_d = (state_d == IDLE);
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    flex_serializer_shreg #(
        .DATA_W (DATA_W),
        .MOD_W  (MOD_W)
    ) u_shreg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .advance_i   (xfer),
        .clear_i     (clear),
        .data_i      (load_data),
        .len_i       (load_len),
        .msb_first_i (load_msb),
        .bit_o       (sh_bit),
        .last_o      (sh_last)
    );

    assign busy_o         = (state_q == SHIFT);
    assign ser_data_val_o = busy_o;
    assign ser_data_o     = busy_o && sh_bit;
    assign ser_last_o     = busy_o && sh_last;
    assign data_rdy_o     = rdy_q;

endmodule

// File: tb/tb_flex_serializer.sv
// Scoreboard bench for flex_serializer: expected {bit,last} pairs are queued when a
// word is offered and popped by a monitor on every serial transfer.
module tb_flex_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_msb_first_i;
    logic        data_val_i;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_last_o;
    logic        ser_ready_i;
    logic        busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_xfer = 0;
    logic [1:0]  exp_q[$];

    flex_serializer u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .data_i           (data_i),
        .data_mod_i       (data_mod_i),
        .data_msb_first_i (data_msb_first_i),
        .data_val_i       (data_val_i),
        .data_rdy_o       (data_rdy_o),
        .ser_data_o       (ser_data_o),
        .ser_data_val_o   (ser_data_val_o),
        .ser_last_o       (ser_last_o),
        .ser_ready_i      (ser_ready_i),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: sample between edges, compare every transfer, check stability under stall.
    logic prev_stall = 1'b0;
    logic prev_bit   = 1'b0;
    logic prev_last  = 1'b0;
    always @(negedge clk_i) begin
        logic [1:0] e;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else if (ser_data_val_o) begin
            if (prev_stall) begin
                check_eq("hold_bit", 32'(ser_data_o), 32'(prev_bit));
                check_eq("hold_last", 32'(ser_last_o), 32'(prev_last));
            end
            if (ser_ready_i) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("ser_bit", 32'(ser_data_o), 32'(e[1]));
                    check_eq("ser_last", 32'(ser_last_o), 32'(e[0]));
                end
            end
            prev_stall = !ser_ready_i;
            prev_bit   = ser_data_o;
            prev_last  = ser_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_word(input logic [15:0] d, input logic [3:0] mod, input logic msb);
        int len;
        len = (mod == 0) ? 16 : int'(mod);
        if (mod != 0 && mod < 3) return;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({msb ? d[15 - i] : d[i], (i == len - 1) ? 1'b1 : 1'b0});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_word(input logic [15:0] d, input logic [3:0] mod, input logic msb);
        int w;
        data_i           = d;
        data_mod_i       = mod;
        data_msb_first_i = msb;
        data_val_i       = 1'b1;
        w = 0;
        while (!data_rdy_o && w < 200) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        if (w >= 200) check_eq("rdy_timeout", 32'd1, 32'd0);
        push_word(d, mod, msb);
        @(posedge clk_i);
        #1;
        data_val_i       = 1'b0;
        data_i           = ~d;
        data_mod_i       = 4'd7;
        data_msb_first_i = ~msb;
    endtask

    task automatic run_until_idle(output int cyc, output int rdy_lo);
        cyc    = 0;
        rdy_lo = 0;
        while (busy_o && cyc < 500) begin
            if (!data_rdy_o) rdy_lo++;
            cyc++;
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        int cyc;
        int lo;
        int x0;
        rst_i            = 1'b1;
        flush_i          = 1'b0;
        data_i           = '0;
        data_mod_i       = '0;
        data_msb_first_i = 1'b0;
        data_val_i       = 1'b0;
        ser_ready_i      = 1'b1;
        #12;
        check_eq("rst_rdy", 32'(data_rdy_o), 32'd0);
        check_eq("rst_val", 32'(ser_data_val_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_last", 32'(ser_last_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_eq("rdy_before_edge", 32'(data_rdy_o), 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("rdy_after_rst", 32'(data_rdy_o), 32'd1);

        // Full word, MSB first
        send_word(16'hA5C3, 4'd0, 1'b1);
        check_eq("lat_val", 32'(ser_data_val_o), 32'd1);
        check_eq("lat_busy", 32'(busy_o), 32'd1);
`ifndef FLEX_SERIALIZER_PRELOAD_EN
        check_eq("rdy_falls", 32'(data_rdy_o), 32'd0);
`endif
        run_until_idle(cyc, lo);
        check_eq("full_len", 32'(cyc), 32'd16);
        check_eq("full_rdy_back", 32'(data_rdy_o), 32'd1);
        check_eq("full_drain", 32'(exp_q.size()), 32'd0);

        // Short word, LSB first
        send_word(16'h00F0, 4'd5, 1'b0);
        run_until_idle(cyc, lo);
        check_eq("short_len", 32'(cyc), 32'd5);
        check_eq("short_rdy_back", 32'(data_rdy_o), 32'd1);

        // Illegal lengths are consumed silently
        for (int m = 1; m <= 2; m++) begin
            send_word(16'hFFFF, 4'(m), 1'b1);
            check_eq("illegal_val", 32'(ser_data_val_o), 32'd0);
            check_eq("illegal_busy", 32'(busy_o), 32'd0);
            check_eq("illegal_rdy", 32'(data_rdy_o), 32'd1);
        end
        send_word(16'h6000, 4'd3, 1'b1);
        run_until_idle(cyc, lo);
        check_eq("min_len", 32'(cyc), 32'd3);

        // Backpressure with ready pattern 1,0,0
        x0 = n_xfer;
        send_word(16'h5A3C, 4'd0, 1'b1);
        cyc = 0;
        while (busy_o && cyc < 200) begin
            ser_ready_i = (cyc % 3 == 0);
            cyc++;
            @(posedge clk_i);
            #1;
        end
        ser_ready_i = 1'b1;
        check_eq("bp_xfers", 32'(n_xfer - x0), 32'd16);
        check_eq("bp_drain", 32'(exp_q.size()), 32'd0);

        // Flush with a word offered in the same cycle: flush wins
        data_i      = 16'hFFFF;
        data_mod_i  = 4'd0;
        data_val_i  = 1'b1;
        flush_i     = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        data_val_i = 1'b0;
        check_eq("flush_win_busy", 32'(busy_o), 32'd0);
        check_eq("flush_win_rdy", 32'(data_rdy_o), 32'd1);

        // Flush mid-word, after four bits have gone out
        send_word(16'hC3A5, 4'd0, 1'b0);
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check_eq("flush_left", 32'(exp_q.size()), 32'd11);
        exp_q.delete();
        check_eq("flush_val", 32'(ser_data_val_o), 32'd0);
        check_eq("flush_busy", 32'(busy_o), 32'd0);
        check_eq("flush_rdy", 32'(data_rdy_o), 32'd1);

        // Async reset between edges
        send_word(16'hFFFF, 4'd0, 1'b1);
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_val", 32'(ser_data_val_o), 32'd0);
        check_eq("arst_data", 32'(ser_data_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_rdy", 32'(data_rdy_o), 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("arst_rdy_back", 32'(data_rdy_o), 32'd1);
        send_word(16'h8001, 4'd4, 1'b0);
        run_until_idle(cyc, lo);
        check_eq("post_rst_len", 32'(cyc), 32'd4);

`ifdef FLEX_SERIALIZER_PRELOAD_EN
        // Back-to-back words through the pending buffer
        send_word(16'hA5C3, 4'd0, 1'b1);
        send_word(16'h1234, 4'd8, 1'b1);
        check_eq("pre_rdy_low", 32'(data_rdy_o), 32'd0);
        run_until_idle(cyc, lo);
        check_eq("pre_busy_span", 32'(cyc), 32'd23);
        check_eq("pre_rdy_lo", 32'(lo), 32'd15);
`endif

        repeat (2) @(posedge clk_i);
        #1;
        check_eq("final_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
